// File: rtl/switch_step_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_step_gen_pkg
//  Description : Shared FSM state encoding, board clock constant and timing
//                defaults for the push-button step generator.
//  Revision    : 1.0  initial release
// ============================================================================
package switch_step_gen_pkg;

    // Board clock frequency; the timing defaults below are derived from it.
    localparam int CLK_HZ = 25_000_000;

    // 10 ms debounce window, 0.5 s first-repeat delay, 0.1 s repeat period.
    localparam int DEF_DEBOUNCE_LIMIT = CLK_HZ / 100;
    localparam int DEF_REPEAT_DELAY   = CLK_HZ / 2;
    localparam int DEF_REPEAT_PERIOD  = CLK_HZ / 10;

    // Step generator FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_t;

    // Larger of two integers; sizes the shared repeat timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : switch_step_gen_pkg
`default_nettype wire

// File: rtl/switch_step_gen_debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_filter
//  Description : Two-flop synchronizer followed by a consecutive-cycle
//                debounce counter. The clean level only flips after the
//                synchronized input has disagreed with it for DEBOUNCE_LIMIT
//                consecutive cycles; shorter glitches are invisible.
//                DEBOUNCE_LIMIT must be >= 2.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_filter
    import switch_step_gen_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Raw,
    output logic o_Clean
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    // Bring the asynchronous switch into the clock domain.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_Raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; flip the clean level at the limit.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            count   <= '0;
            o_Clean <= 1'b0;
        end else if (sync2 != o_Clean) begin
            if (count == CNT_LAST) begin
                o_Clean <= sync2;
                count   <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count <= '0;
        end
    end

endmodule : debounce_filter
`default_nettype wire

// File: rtl/switch_step_gen.sv
`default_nettype none
// ============================================================================
//  Module      : switch_step_gen
//  Description : Turns a raw bouncy push-button into single-cycle step
//                pulses: one step per press, then auto-repeat after
//                REPEAT_DELAY cycles every REPEAT_PERIOD cycles while held.
//                Release always wins over a coincident timer expiry.
//                All parameters must be >= 2.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_step_gen
    import switch_step_gen_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch_Clean,
    output logic o_Step,
    output logic o_Repeating
);

    // One timer serves both the first delay and the repeat period.
    localparam int TMR_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic             filtered;
    logic [TMR_W-1:0] timer;
    step_state_t      state;

    debounce_filter #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Raw   (i_Switch),
        .o_Clean (filtered)
    );

    // Register the debounced level; the FSM works from this registered copy.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Switch_Clean <= 1'b0;
        end else begin
            o_Switch_Clean <= filtered;
        end
    end

    // Step FSM with repeat timer; o_Step and o_Repeating registered with state.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            o_Step      <= 1'b0;
            o_Repeating <= 1'b0;
        end else begin
            o_Step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_Repeating <= 1'b0;
                    if (o_Switch_Clean) begin
                        o_Step <= 1'b1;
                        timer  <= '0;
                        state  <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!o_Switch_Clean) begin
                        state       <= ST_IDLE;
                        o_Repeating <= 1'b0;
                    end else if (timer == DELAY_LAST) begin
                        o_Step      <= 1'b1;
                        timer       <= '0;
                        state       <= ST_REPEAT;
                        o_Repeating <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!o_Switch_Clean) begin
                        state       <= ST_IDLE;
                        o_Repeating <= 1'b0;
                    end else if (timer == PERIOD_LAST) begin
                        o_Step <= 1'b1;
                        timer  <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    timer       <= '0;
                    o_Repeating <= 1'b0;
                end
            endcase
        end
    end

endmodule : switch_step_gen
`default_nettype wire
